// File: rtl/npu_queue_unit.sv
// npu_queue_unit: the FIFOs on the CPU/NPU boundary, and the responder for the
// EX-stage NPU ops.
//   config queue : CPU (iExNpuCfgOp) -> NPU (oNpuCfg*/iNpuCfgReady)
//   input queue  : CPU (iExNpuEnqOp) -> NPU (oNpuIn*/iNpuInReady)
//   output queue : NPU (iNpuOutValid/oNpuOutReady) -> CPU (iExNpuDeqOp/oCpuData)
// Ports:
//   iClk, iRst       clock and synchronous active-high reset
//   iExNpu*Op        EX-stage ops; they commit only while iStall is low
//   iCpuData         write data for cfg/enq ops
//   oCpuData         output-queue head (first-word fall-through, 0 when empty)
//   oNpu*Full/Empty  queue flags for the hazard logic, taken from registered counts
//   oNpuCfg*/oNpuIn* valid/data heads toward the NPU
//   iNpuOut*         NPU result handshake
//   oProtocolErr     sticky: a CPU op hit a full/empty queue while not stalled

module npu_queue_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // Gating uses the registered flags: a push into a full queue or a pop from an
  // empty one is dropped, so an empty queue never bypasses write data to head.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Contents need no reset: the head is masked to zero while the queue is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module npu_queue_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CFG_DEPTH  = 8,
  parameter int unsigned IN_DEPTH   = 8,
  parameter int unsigned OUT_DEPTH  = 8
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iExNpuCfgOp,
  input  logic                  iExNpuEnqOp,
  input  logic                  iExNpuDeqOp,
  input  logic                  iStall,
  input  logic [DATA_WIDTH-1:0] iCpuData,
  output logic [DATA_WIDTH-1:0] oCpuData,
  output logic                  oNpuConfigFull,
  output logic                  oNpuInputFull,
  output logic                  oNpuOutputEmpty,
  output logic                  oNpuCfgValid,
  output logic [DATA_WIDTH-1:0] oNpuCfgData,
  input  logic                  iNpuCfgReady,
  output logic                  oNpuInValid,
  output logic [DATA_WIDTH-1:0] oNpuInData,
  input  logic                  iNpuInReady,
  input  logic                  iNpuOutValid,
  input  logic [DATA_WIDTH-1:0] iNpuOutData,
  output logic                  oNpuOutReady,
  output logic                  oProtocolErr
);
  logic cfg_full, cfg_empty;
  logic in_full, in_empty;
  logic out_full, out_empty;
  logic err_q, err_d;

  npu_queue_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(CFG_DEPTH)) u_cfg_q (
    .clk   (iClk),
    .rst   (iRst),
    .push  (iExNpuCfgOp & ~iStall),
    .pop   (iNpuCfgReady),
    .wdata (iCpuData),
    .head  (oNpuCfgData),
    .full  (cfg_full),
    .empty (cfg_empty)
  );

  npu_queue_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_in_q (
    .clk   (iClk),
    .rst   (iRst),
    .push  (iExNpuEnqOp & ~iStall),
    .pop   (iNpuInReady),
    .wdata (iCpuData),
    .head  (oNpuInData),
    .full  (in_full),
    .empty (in_empty)
  );

  npu_queue_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_out_q (
    .clk   (iClk),
    .rst   (iRst),
    .push  (iNpuOutValid),
    .pop   (iExNpuDeqOp & ~iStall),
    .wdata (iNpuOutData),
    .head  (oCpuData),
    .full  (out_full),
    .empty (out_empty)
  );

  assign oNpuConfigFull  = cfg_full;
  assign oNpuInputFull   = in_full;
  assign oNpuOutputEmpty = out_empty;
  assign oNpuCfgValid    = ~cfg_empty;
  assign oNpuInValid     = ~in_empty;
  assign oNpuOutReady    = ~out_full;
  assign oProtocolErr    = err_q;

  always_comb begin
    err_d = err_q;
    if (~iStall & ((iExNpuCfgOp & cfg_full) |
                   (iExNpuEnqOp & in_full)  |
                   (iExNpuDeqOp & out_empty))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
endmodule

// File: doc/npu_queue_unit.md
Name: npu_queue_unit

Overview:
CPU/NPU boundary queue block, and the responder for the EX-stage NPU ops. It holds three FIFOs:
- config queue: CPU to NPU
- input queue: CPU to NPU
- output queue: NPU to CPU

It produces the full/empty flags the hazard logic turns into pipeline stalls. CPU-side ops commit only in non-stalled cycles; the NPU side uses valid/ready handshakes.

Parameters:
DATA_WIDTH, 32, width of every queue entry
CFG_DEPTH, 8, config queue entries (power of two, >=2)
IN_DEPTH, 8, input queue entries (power of two, >=2)
OUT_DEPTH, 8, output queue entries (power of two, >=2)

Ports:
iClk  input  1  clock, single domain, all state on rising edge
iRst  input  1  synchronous active-high reset
iExNpuCfgOp  input  1  EX-stage config-write op
iExNpuEnqOp  input  1  EX-stage input-enqueue op
iExNpuDeqOp  input  1  EX-stage output-dequeue op
iStall  input  1  pipeline stall; CPU-side ops ignored while high
iCpuData  input  DATA_WIDTH  write data for cfg/enq ops
oCpuData  output  DATA_WIDTH  output-queue head (first-word fall-through)
oNpuConfigFull  output  1  config queue full
oNpuInputFull  output  1  input queue full
oNpuOutputEmpty  output  1  output queue empty
oNpuCfgValid  output  1  config queue head valid
oNpuCfgData  output  DATA_WIDTH  config queue head
iNpuCfgReady  input  1  NPU consumes config head
oNpuInValid  output  1  input queue head valid
oNpuInData  output  DATA_WIDTH  input queue head
iNpuInReady  input  1  NPU consumes input head
iNpuOutValid  input  1  NPU result valid
iNpuOutData  input  DATA_WIDTH  NPU result
oNpuOutReady  output  1  output queue can accept
oProtocolErr  output  1  sticky: CPU op attempted on full/empty queue while not stalled

Behaviour:
- Each queue has:
  - storage array
  - rd/wr pointers of log2(DEPTH) bits, wrapping modulo DEPTH
  - count register of log2(DEPTH)+1 bits
- Flags come from the registered count only: full = (count==DEPTH), empty = (count==0). There is no combinational path from the same-cycle push/pop to the flags.
- Reset, synchronous, iRst high at an edge:
  - all pointers and counts go to 0
  - all full flags go to 0; oNpuOutputEmpty goes to 1
  - oNpuCfgValid, oNpuInValid and oProtocolErr go to 0; oNpuOutReady goes to 1
  - queue contents are discarded
  - reset overrides any same-cycle push/pop, including mid-handshake.
- Head data outputs (oCpuData, oNpuCfgData, oNpuInData) are 0 whenever their queue is empty. Otherwise they show the head entry in the same cycle (zero-latency read).
- CPU push: accepted when op & ~iStall & ~full. iCpuData is written at wr_ptr and wr_ptr increments.
- CPU pop: accepted when iExNpuDeqOp & ~iStall & ~oNpuOutputEmpty. oCpuData is valid in that same cycle and rd_ptr increments.
- NPU pop (cfg/in): the handshake completes when Valid & Ready; the head advances at that edge.
- NPU push: accepted when iNpuOutValid & oNpuOutReady, with oNpuOutReady = ~(out count==OUT_DEPTH).
- Simultaneous accepted push and pop on one queue: both pointers advance and count is unchanged.
  - When full: the push is rejected, the pop proceeds, count becomes DEPTH-1.
  - When empty: the pop is rejected (no bypass), the push proceeds, count becomes 1, and the entry is visible next cycle.
- oProtocolErr is set at the edge where any of these holds:
  - (iExNpuCfgOp & full_cfg & ~iStall)
  - (iExNpuEnqOp & full_in & ~iStall)
  - (iExNpuDeqOp & empty_out & ~iStall)
  It is cleared only by iRst. The rejected op has no other effect.
- Multiple CPU op inputs high in one cycle: each is evaluated independently against its own queue.
- Latency:
  - CPU write to NPU-visible Valid: 1 cycle.
  - NPU result to CPU-visible oCpuData / ~oNpuOutputEmpty: 1 cycle.

Test Plan:
- Reset then 8 enq ops (iStall=0, data 0x10..0x17), iNpuInReady=0 -> oNpuInputFull=1 after 8th edge; oNpuInValid=1, oNpuInData=0x10.
- Full input queue, iExNpuEnqOp=1 & iNpuInReady=1 in the same cycle -> push rejected; count=7; oNpuInData becomes 0x11; oProtocolErr=1.
- Empty output queue, iNpuOutValid=1 data 0xABCD & iExNpuDeqOp=1 in the same cycle -> pop rejected; oProtocolErr=1; next cycle oNpuOutputEmpty=0, oCpuData=0xABCD.
- Cfg op with iStall=1 -> no push, count stays 0, oProtocolErr stays 0; release stall -> entry pushed, oNpuCfgValid=1 next cycle.
- Wrap-around: 20 interleaved push/pop pairs through the output queue with values 1..20 -> FIFO order is preserved across pointer wrap; empty/full are never asserted falsely.
- iRst asserted with all queues partially full and a handshake active -> after the edge, all counts are 0, Valids are 0, oNpuOutputEmpty=1, oProtocolErr=0.
